// File: rtl/mac_arbiter_pkg.sv
// Shared types and defaults for the two-requester MAC/ROM datapath arbiter.
package mac_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam int unsigned REQ_0 = 0;
  localparam int unsigned REQ_1 = 1;

  localparam int unsigned DEFAULT_ADDR_W    = 6;
  localparam int unsigned DEFAULT_BURST_LEN = 64;

endpackage

// File: rtl/mac_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the requester that was not
// served last wins. Result is one-hot, or zero when nobody requests.
module rr_pick2
  import mac_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_served ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin owner of the shared MAC + coefficient ROM for two transform controllers.
// Define MAC_ARB_WATCHDOG_EN to add the burst-length watchdog driving overrun.
module mac_arbiter
  import mac_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            done,
  input  logic [1:0]            rd_en_i,
  input  logic [1:0]            act_i,
  input  logic [1:0]            rst_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic                  read_enable,
  output logic                  active_MAC,
  output logic                  reset_MAC,
  output logic [ADDR_W-1:0]     address,
  output logic                  overrun
);

  arb_state_e  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;
  logic [1:0]  pick;
  logic        grant_new;
  logic        owner_act;

  rr_pick2 u_pick (
    .req         (req),
    .last_served (last_q),
    .pick        (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        if (pick[REQ_0]) begin
          state_d = ST_G0;
          gnt_d   = pick;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end else if (pick[REQ_1]) begin
          state_d = ST_G1;
          gnt_d   = pick;
          busy_d  = 1'b1;
          last_d  = 1'b1;
        end
      end
      // Dropping req is treated exactly like done: the owner gives up the datapath.
      ST_G0: begin
        if (done[REQ_0] || !req[REQ_0]) begin
          state_d = ST_GAP;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
        end
      end
      ST_G1: begin
        if (done[REQ_1] || !req[REQ_1]) begin
          state_d = ST_GAP;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign grant_new = busy_d & ~busy_q;
  assign owner_act = |(act_i & gnt_q);

  // Zero-latency passthrough selected by the registered grant.
  always_comb begin
    read_enable = 1'b0;
    active_MAC  = 1'b0;
    reset_MAC   = 1'b0;
    address     = '0;
    if (gnt_q[REQ_0]) begin
      read_enable = rd_en_i[REQ_0];
      active_MAC  = act_i[REQ_0];
      reset_MAC   = rst_i[REQ_0];
      address     = addr_i[REQ_0*ADDR_W +: ADDR_W];
    end else if (gnt_q[REQ_1]) begin
      read_enable = rd_en_i[REQ_1];
      active_MAC  = act_i[REQ_1];
      reset_MAC   = rst_i[REQ_1];
      address     = addr_i[REQ_1*ADDR_W +: ADDR_W];
    end
  end

`ifdef MAC_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(BURST_LEN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  // Count granted act pulses, saturating one past the legal burst length.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_new) begin
      cnt_d = '0;
    end else if (owner_act && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    overrun_d = overrun_q | (cnt_d == CNT_SAT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mac_arbiter.sv
// Scoreboard bench for mac_arbiter: a cycle-level reference model predicts the owner
// and overrun flag, a negedge monitor compares grant, busy, overrun and passthrough.
module tb_mac_arbiter;

  localparam int AW = 6;
  localparam int BL = 64;
`ifdef MAC_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req   = 2'b00;
  logic [1:0]    done  = 2'b00;
  logic [1:0]    rd_en = 2'b00;
  logic [1:0]    act   = 2'b00;
  logic [1:0]    rstm  = 2'b00;
  logic [2*AW-1:0] addr = '0;

  logic [1:0]    gnt;
  logic          busy;
  logic          read_enable;
  logic          active_MAC;
  logic          reset_MAC;
  logic [AW-1:0] address;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int mac_pulses = 0;

  always #5 clock = ~clock;

  mac_arbiter #(.ADDR_W(AW), .BURST_LEN(BL)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .rd_en_i     (rd_en),
    .act_i       (act),
    .rst_i       (rstm),
    .addr_i      (addr),
    .gnt         (gnt),
    .busy        (busy),
    .read_enable (read_enable),
    .active_MAC  (active_MAC),
    .reset_MAC   (reset_MAC),
    .address     (address),
    .overrun     (overrun)
  );

  typedef struct {
    int owner;
    bit ovr;
  } exp_t;

  exp_t exp_q[$];

  int m_owner = -1;
  int m_last  = 1;
  int m_cnt   = 0;
  bit m_ovr   = 1'b0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [AW+2:0] shared_out();
    return {read_enable, active_MAC, reset_MAC, address};
  endfunction

  // Reference model: who owns the datapath after each edge, from the arbitration rules.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner = -1;
      m_last  = 1;
      m_cnt   = 0;
      m_ovr   = 1'b0;
      exp_q.delete();
    end else begin
      if (m_owner >= 0) begin
        if (act[m_owner] && m_cnt < BL + 1) m_cnt++;
        if (WD_ON && m_cnt == BL + 1) m_ovr = 1'b1;
        if (done[m_owner] || !req[m_owner]) m_owner = -1;
      end else begin
        if (req == 2'b11)  m_owner = 1 - m_last;
        else if (req[0])   m_owner = 0;
        else if (req[1])   m_owner = 1;
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_cnt  = 0;
        end
      end
      exp_q.push_back('{m_owner, m_ovr});
    end
  end

  // Monitor: pop the prediction for this cycle and compare everything the DUT shows.
  always @(negedge clock) begin : monitor
    exp_t e;
    logic [1:0] eg;
    logic [AW+2:0] es;
    if (!reset) begin
      check_output("rst_gnt", {30'b0, gnt}, 32'd0);
      check_output("rst_busy", {31'b0, busy}, 32'd0);
      check_output("rst_shared", 32'(shared_out()), 32'd0);
      check_output("rst_overrun", {31'b0, overrun}, 32'd0);
    end else begin
      e.owner = -1;
      e.ovr   = 1'b0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      eg = (e.owner == 0) ? 2'b01 : (e.owner == 1) ? 2'b10 : 2'b00;
      es = '0;
      if (e.owner >= 0)
        es = {rd_en[e.owner], act[e.owner], rstm[e.owner], addr[e.owner*AW +: AW]};
      check_output("gnt", {30'b0, gnt}, {30'b0, eg});
      check_output("busy", {31'b0, busy}, {31'b0, (e.owner >= 0)});
      check_output("overrun", {31'b0, overrun}, {31'b0, e.ovr});
      check_output("shared", 32'(shared_out()), 32'(es));
      if (active_MAC) mac_pulses++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    done  = 2'b00;
    rd_en = 2'b00;
    act   = 2'b00;
    rstm  = 2'b00;
  endtask

  task automatic wait_gnt(input int who);
    int n = 0;
    while (!gnt[who] && n < 300) begin
      tick();
      n++;
    end
    check_output("wait_gnt", {31'b0, gnt[who]}, 32'd1);
  endtask

  // Runs a granted burst: n_act act cycles, then a done cycle (optionally with act).
  task automatic apply_stimulus(input int who, input int n_act, input bit act_on_done, input bit drop_req);
    int other = 1 - who;
    for (int k = 0; k < n_act; k++) begin
      rd_en[who] = 1'b1;
      act[who]   = 1'b1;
      rstm[who]  = (k == 0);
      addr[who*AW +: AW]     = AW'($urandom);
      addr[other*AW +: AW]   = AW'($urandom);
      rd_en[other] = 1'($urandom);
      act[other]   = 1'($urandom);
      rstm[other]  = 1'($urandom);
      tick();
    end
    rstm       = 2'b00;
    done[who]  = 1'b1;
    act[who]   = act_on_done;
    rd_en[who] = act_on_done;
    tick();
    idle_inputs();
    if (drop_req) req[who] = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_output({tag, "_gnt"}, {30'b0, gnt}, 32'd0);
    check_output({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_output({tag, "_shared"}, 32'(shared_out()), 32'd0);
    check_output({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int left[2];
    bit fin[2];
    int base;
    int who;

    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Single requester, full 64-pulse burst.
    req[0] = 1'b1;
    tick();
    check_output("s1_latency", {30'b0, gnt}, 32'h1);
    base = mac_pulses;
    apply_stimulus(0, 64, 1'b0, 1'b1);
    check_output("s1_pulses", 32'(mac_pulses - base), 32'd64);
    check_output("s1_release", {30'b0, gnt}, 32'd0);
    check_output("s1_overrun", {31'b0, overrun}, 32'd0);

    // Tie after reset: both hold req, three bursts each.
    do_reset("tie_reset");
    req = 2'b11;
    tick();
    for (int b = 0; b < 6; b++) begin
      check_output("tie_order", {30'b0, gnt}, (b % 2 == 0) ? 32'h1 : 32'h2);
      who = gnt[1] ? 1 : 0;
      apply_stimulus(who, $urandom_range(1, 10), 1'($urandom), b >= 4);
      check_output("tie_gap", {30'b0, gnt}, 32'd0);
      if (b < 5) tick();
    end

    // Fairness: requester 0 keeps requesting, requester 1 arrives mid-burst.
    req[0] = 1'b1;
    tick();
    check_output("fair_first", {30'b0, gnt}, 32'h1);
    req[1] = 1'b1;
    apply_stimulus(0, 8, 1'b1, 1'b0);
    tick();
    check_output("fair_next", {30'b0, gnt}, 32'h2);
    apply_stimulus(1, 5, 1'b0, 1'b1);
    tick();
    check_output("fair_back", {30'b0, gnt}, 32'h1);
    apply_stimulus(0, 4, 1'b0, 1'b1);

    // Randomised controllers with spurious done, aborts and re-requests.
    left = '{0, 0};
    fin  = '{1'b0, 1'b0};
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        done[i] = 1'b0;
        act[i]  = 1'b0;
        rd_en[i] = 1'b0;
        rstm[i] = 1'b0;
        addr[i*AW +: AW] = AW'($urandom);
        if (fin[i]) begin
          fin[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          left[i] = $urandom_range(1, 12);
        end
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i]  = 1'b1;
            left[i] = $urandom_range(1, 12);
          end
        end else if (gnt[i]) begin
          act[i] = 1'($urandom);
          if (left[i] == 0) begin
            if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            else begin
              done[i] = 1'b1;
              fin[i]  = 1'b1;
            end
          end else begin
            left[i]--;
            rd_en[i] = 1'($urandom);
            rstm[i]  = ($urandom_range(0, 5) == 0);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          done[i] = 1'b1;
        end
      end
      tick();
    end
    req = 2'b00;
    idle_inputs();
    repeat (3) tick();

    // Overrun: 65th act pulse arrives together with done.
    req[0] = 1'b1;
    wait_gnt(0);
    apply_stimulus(0, 64, 1'b1, 1'b1);
    check_output("ovr_after_done", {31'b0, overrun}, {31'b0, WD_ON});
    repeat (2) tick();
    check_output("ovr_sticky", {31'b0, overrun}, {31'b0, WD_ON});

    // Abort by requester 1, then async reset in the middle of requester 0's burst.
    req[1] = 1'b1;
    wait_gnt(1);
    for (int k = 0; k < 3; k++) begin
      act[1]   = 1'b1;
      rd_en[1] = 1'b1;
      addr[AW +: AW] = AW'($urandom);
      tick();
    end
    req[1] = 1'b0;
    tick();
    check_output("abort_gnt", {30'b0, gnt}, 32'd0);
    check_output("abort_shared", 32'(shared_out()), 32'd0);
    idle_inputs();
    req[0] = 1'b1;
    wait_gnt(0);
    act[0]   = 1'b1;
    rd_en[0] = 1'b1;
    addr[0 +: AW] = 6'h2A;
    tick();
    tick();
    do_reset("midburst_reset");
    req = 2'b11;
    idle_inputs();
    tick();
    check_output("post_reset_first", {30'b0, gnt}, 32'h1);
    apply_stimulus(0, 3, 1'b0, 1'b1);
    wait_gnt(1);
    apply_stimulus(1, 3, 1'b0, 1'b1);
    repeat (3) tick();

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
